// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Holds the access-size codes, FSM state type and the request error check.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // True when the access is misaligned, has an illegal size, or falls past the RAM.
  function automatic logic access_error(input logic [1:0] size,
                                        input logic [31:0] addr,
                                        input int unsigned idx_bits);
    logic misaligned;
    logic out_of_range;
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = addr[0];
      SIZE_W:  misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    out_of_range = ((addr >> (idx_bits + 2)) != 32'd0);
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data RAM: merges store data into the old word
// and extracts/extends load data from it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] new_word,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = old_word[{offset, 3'b000} +: 8];
  assign lane_h = old_word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    new_word  = old_word;
    load_data = 32'd0;
    case (size)
      SIZE_B: begin
        new_word[{offset, 3'b000} +: 8] = wdata[7:0];
        load_data = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SIZE_H: begin
        new_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      SIZE_W: begin
        new_word  = wdata;
        load_data = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time, with a fixed
// number of wait states between request accept and the RAM access edge.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the initiator holds its payload while valid is high and ready is low, and
// the responder holds rsp_valid/rsp_rdata/rsp_err stable until rsp_ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WORDS = 256,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(ADDR_WORDS);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             cap_we;
  logic [31:0]      cap_addr;
  logic [31:0]      cap_wdata;
  logic [1:0]       cap_size;
  logic             cap_unsigned;

  logic [31:0]      mem [ADDR_WORDS];

  logic             accept;
  logic             acc_fire;
  logic             acc_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      old_word;
  logic [31:0]      new_word;
  logic [31:0]      load_data;

  assign req_ready = (state == IDLE) && rst;
  assign accept    = req_valid && req_ready;
  assign acc_fire  = (state == WAIT) && (cnt == '0);
  assign acc_err   = access_error(cap_size, cap_addr, IDX_W);
  assign idx       = cap_addr[IDX_W+1:2];
  assign old_word  = mem[idx];

  dmem_lane_align u_align (
    .old_word    (old_word),
    .wdata       (cap_wdata),
    .size        (cap_size),
    .offset      (cap_addr[1:0]),
    .is_unsigned (cap_unsigned),
    .new_word    (new_word),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = WAIT;
      WAIT:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      cap_we       <= 1'b0;
      cap_addr     <= 32'd0;
      cap_wdata    <= 32'd0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        cap_we       <= req_we;
        cap_addr     <= req_addr;
        cap_wdata    <= req_wdata;
        cap_size     <= req_size;
        cap_unsigned <= req_unsigned;
        cnt          <= LAT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (acc_fire) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || cap_we) ? 32'd0 : load_data;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && acc_fire && cap_we && !acc_err) mem[idx] <= new_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of transactions against a
// LATENCY=2 and a LATENCY=0 instance, plus backpressure and mid-wait reset sequences.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_uns;
  logic        rsp_ready;
  logic        sel;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;

  int checks;
  int errors;

  assign cur_req_ready = sel ? b_req_ready : a_req_ready;
  assign cur_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign cur_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign cur_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  dmem_responder #(.ADDR_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_uns),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.ADDR_WORDS(256), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(b_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_uns),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        l0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic l0, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.l0 = l0; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
    v.uns = uns; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request, waits for its response with rsp_ready high, and returns
  // the response plus the number of edges from accept to rsp_valid (99 on timeout).
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_uns = uns; rsp_ready = 1'b1;
    n = 0;
    while (!cur_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    rdata = 32'hx; err = 1'bx; lat = 99;
    if (!cur_req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!cur_rsp_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    if (cur_rsp_valid) begin
      lat   = n;
      rdata = cur_rsp_rdata;
      err   = cur_rsp_err;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    checks = 0; errors = 0; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'b10; req_uns = 1'b0; rsp_ready = 1'b0;

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'd0, a_req_ready}, 32'd0);
    check("reset rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("reset rsp_rdata", a_rsp_rdata, 32'd0);
    check("reset rsp_err", {31'd0, a_rsp_err}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("release req_ready", {31'd0, a_req_ready}, 32'd1);

    //   l0    we    addr          wdata          size   uns   exp_rdata      err
    add(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0,         1'b0);
    add(1'b0, 1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF,  1'b0);
    add(1'b0, 1'b1, 32'h21,  32'h80,       2'b00, 1'b0, 32'h0,         1'b0);
    add(1'b0, 1'b0, 32'h21,  32'h0,        2'b00, 1'b0, 32'hFFFFFF80,  1'b0);
    add(1'b0, 1'b0, 32'h21,  32'h0,        2'b00, 1'b1, 32'h00000080,  1'b0);
    add(1'b0, 1'b0, 32'h20,  32'h0,        2'b10, 1'b0, 32'h00008000,  1'b0);
    add(1'b0, 1'b1, 32'h20,  32'h80011234, 2'b10, 1'b0, 32'h0,         1'b0);
    add(1'b0, 1'b0, 32'h22,  32'h0,        2'b01, 1'b0, 32'hFFFF8001,  1'b0);
    add(1'b0, 1'b0, 32'h22,  32'h0,        2'b01, 1'b1, 32'h00008001,  1'b0);
    add(1'b0, 1'b0, 32'h23,  32'h0,        2'b01, 1'b0, 32'h0,         1'b1);
    add(1'b0, 1'b1, 32'h23,  32'hFFFF,     2'b01, 1'b0, 32'h0,         1'b1);
    add(1'b0, 1'b0, 32'h20,  32'h0,        2'b10, 1'b0, 32'h80011234,  1'b0);
    add(1'b0, 1'b1, 32'h0,   32'hCAFEF00D, 2'b10, 1'b0, 32'h0,         1'b0);
    add(1'b0, 1'b1, 32'h400, 32'h11111111, 2'b10, 1'b0, 32'h0,         1'b1);
    add(1'b0, 1'b1, 32'h0,   32'h22222222, 2'b11, 1'b0, 32'h0,         1'b1);
    add(1'b0, 1'b0, 32'h0,   32'h0,        2'b10, 1'b0, 32'hCAFEF00D,  1'b0);
    add(1'b0, 1'b0, 32'h3,   32'h0,        2'b00, 1'b0, 32'hFFFFFFCA,  1'b0);
    add(1'b0, 1'b0, 32'h0,   32'h0,        2'b01, 1'b0, 32'hFFFFF00D,  1'b0);
    add(1'b0, 1'b1, 32'h2,   32'h000000A5, 2'b01, 1'b0, 32'h0,         1'b0);
    add(1'b0, 1'b0, 32'h0,   32'h0,        2'b10, 1'b0, 32'h00A5F00D,  1'b0);
    add(1'b0, 1'b1, 32'h1,   32'hFFFFFF77, 2'b00, 1'b0, 32'h0,         1'b0);
    add(1'b0, 1'b0, 32'h0,   32'h0,        2'b10, 1'b0, 32'h00A5770D,  1'b0);
    add(1'b0, 1'b0, 32'h2,   32'h0,        2'b10, 1'b0, 32'h0,         1'b1);
    add(1'b0, 1'b1, 32'h3FC, 32'h13579BDF, 2'b10, 1'b0, 32'h0,         1'b0);
    add(1'b0, 1'b0, 32'h3FC, 32'h0,        2'b10, 1'b0, 32'h13579BDF,  1'b0);
    add(1'b0, 1'b0, 32'h3FF, 32'h0,        2'b00, 1'b1, 32'h00000013,  1'b0);
    add(1'b0, 1'b0, 32'h400, 32'h0,        2'b10, 1'b0, 32'h0,         1'b1);
    add(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,   2'b00, 1'b0, 32'h0,         1'b1);
    add(1'b1, 1'b1, 32'h8,   32'h12345678, 2'b10, 1'b0, 32'h0,         1'b0);
    add(1'b1, 1'b0, 32'h8,   32'h0,        2'b10, 1'b0, 32'h12345678,  1'b0);
    add(1'b1, 1'b0, 32'hA,   32'h0,        2'b01, 1'b0, 32'h00001234,  1'b0);
    add(1'b1, 1'b0, 32'hB,   32'h0,        2'b00, 1'b1, 32'h00000012,  1'b0);

    foreach (vecs[i]) begin
      sel = vecs[i].l0;
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d latency", i), 32'(lat), vecs[i].l0 ? 32'd1 : 32'd3);
    end
    sel = 1'b0;

    // backpressure: response held while a second request waits unaccepted
    txn(1'b1, 32'h40, 32'hA5A55A5A, 2'b10, 1'b0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'b10;
    req_uns = 1'b0; rsp_ready = 1'b0;
    check("bp req_ready idle", {31'd0, cur_req_ready}, 32'd1);
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'h0;
    n = 0;
    while (!cur_rsp_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp latency", 32'(n), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d rsp_valid", k), {31'd0, cur_rsp_valid}, 32'd1);
      check($sformatf("bp%0d rsp_rdata", k), cur_rsp_rdata, 32'hA5A55A5A);
      check($sformatf("bp%0d req_ready", k), {31'd0, cur_req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp rsp_valid cleared", {31'd0, cur_rsp_valid}, 32'd0);
    check("bp req_ready after handshake", {31'd0, cur_req_ready}, 32'd1);
    txn(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check("bp second store dropped", rd, 32'hA5A55A5A);

    // reset during WAIT of a store
    txn(1'b1, 32'h30, 32'h0, 2'b10, 1'b0, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check("pre-reset load", rd, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55;
    req_size = 2'b10; req_uns = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid reset req_ready", {31'd0, a_req_ready}, 32'd0);
    check("mid reset rsp_rdata", a_rsp_rdata, 32'd0);
    check("mid reset rsp_err", {31'd0, a_rsp_err}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check($sformatf("mid reset%0d rsp_valid", k), {31'd0, a_rsp_valid}, 32'd0);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("post reset req_ready", {31'd0, a_req_ready}, 32'd1);
    check("post reset rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    txn(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check("aborted store not committed", rd, 32'h0);
    check("aborted store load err", {31'd0, er}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving load/store requests issued by the pipeline's memory stage over a valid/ready request channel and a valid/ready response channel. Owns a word-organised RAM with byte/halfword/word access, sign/zero extension, misalignment and range checking, and a programmable wait-state latency. Handles one outstanding transaction at a time. Sits between the MEM stage (initiator) and the data RAM, replacing direct array access so the stage can stall on memory.

## Interface
- `ADDR_WORDS`, default 256: RAM depth in 32-bit words; power of two, 16..65536.
- `LATENCY`, default 2: wait cycles inserted before the access edge; legal range 0..15.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous and active-low (asserted when 0).
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept; request accepted on an edge with `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: initiator accepts response; completes on an edge with `rsp_valid && rsp_ready`.
- `rsp_rdata` out 32: load data (extended); 0 for stores and errors.
- `rsp_err` out 1: misaligned, illegal size, or out-of-range address.

## Operation
- FSM states IDLE, WAIT, RESP. `req_ready` = (state == IDLE) && `rst`; registered outputs otherwise.
- IDLE: on request accept, capture we/addr/wdata/size/unsigned, load counter with `LATENCY`, go WAIT.
- WAIT: counter != 0 -> decrement. Counter == 0 -> perform access this edge, register `rsp_rdata`/`rsp_err`, set `rsp_valid`, go RESP.
- RESP: hold `rsp_valid`, `rsp_rdata`, `rsp_err` stable until `rsp_ready`; on handshake clear `rsp_valid`, go IDLE.
- Word index = addr[log2(ADDR_WORDS)+1:2]. Error when size==11, half with addr[0]=1, word with addr[1:0]!=0, or addr >= 4*ADDR_WORDS.
- Error: no RAM write, `rsp_rdata` = 0, `rsp_err` = 1. Otherwise `rsp_err` = 0.
- Store byte: wdata[7:0] written to lane addr[1:0], other lanes unchanged. Store half: wdata[15:0] to lanes {addr[1],0}+1:+0. Store word: full write.
- Load: extract lane(s) by addr[1:0], extend to 32 bits per `req_unsigned`; stores return `rsp_rdata` = 0.
- `req_valid` while not IDLE is ignored (`req_ready` = 0). `rsp_ready` while `rsp_valid` = 0 is ignored.
- RAM not cleared by reset; initialised to zero at simulation start.

## Timing
- Reset (`rst` = 0 at edge): state IDLE, counter 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0; `req_ready` 0 while `rst` low, 1 the cycle after release.
- Request accepted at edge t -> access edge t+1+LATENCY -> `rsp_valid` high from t+1+LATENCY.
- Response handshake at edge r -> `req_ready` high in cycle after r; minimum accept-to-accept spacing LATENCY+3 edges with `rsp_ready` tied high.
- Store visible to a subsequent load on the next transaction (write commits at access edge).
- Reset mid-transaction: abandon; a store whose access edge has not occurred is not committed; no response produced.
- Counter width 4 bits; no wrap (loaded once, counts down to 0).

## Structure
- Package `dmem_pkg`: size encodings SIZE_B/SIZE_H/SIZE_W, FSM state enum, helper for error check.
- Sub-module `dmem_lane_align` (combinational): store lane merge (old word, wdata, size, offset -> new word) and load extract/extend. Top holds FSM, capture registers, counter, RAM.

## Test plan
- Reset, LATENCY=2: store word 0xDEADBEEF to 0x10, load 0x10 -> `rsp_rdata` 0xDEADBEEF, `rsp_valid` 3 edges after accept, `rsp_err` 0.
- Byte stores 0x80 to 0x21 then load signed byte 0x21 -> 0xFFFFFF80; unsigned -> 0x00000080; load word 0x20 -> 0x00008000.
- Signed half load at 0x22 after word store 0x8001_1234 to 0x20 -> 0xFFFF8001; misaligned half at 0x23 -> `rsp_err` 1, rdata 0, RAM unchanged.
- Store to 0x400 (ADDR_WORDS=256) and size=11 -> `rsp_err` 1, no write (verify word 0 unchanged).
- Backpressure: hold `rsp_ready` 0 for 5 cycles -> `rsp_valid`/data stable, `req_ready` 0, second `req_valid` not accepted.
- Assert `rst`=0 during WAIT of store 0x55 to 0x30 -> no response; later load 0x30 returns prior value 0; LATENCY=0 variant responds 1 edge after accept.
